hazard_detection_unit: RTL and testbench

- Producer-side counterpart of the EX-stage bypass logic in the 5-stage RV32 pipeline.
- Sits at the ID stage and detects hazards that bypassing cannot resolve: load-use, pending multi-cycle mul/div results (per-register scoreboard), mul/div structural conflict, and taken-branch redirect.
- Drives stall and flush controls to the IF/ID and ID/EX pipeline registers; tracks in-flight mul/div destinations across cycles.

---
 rtl/hazard_detection_unit_pkg.sv | 28 ++
 rtl/hazard_detection_unit_scoreboard.sv | 60 ++++++
 rtl/hazard_detection_unit.sv | 147 ++++++++++++++
 tb/tb_hazard_detection_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_detection_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detection_unit_pkg
// Description : Shared types and constants for the ID-stage hazard detection
//               unit and its scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_detection_unit_pkg;

    // Architectural x0: never a hazard source or destination
    localparam int REG_ZERO = 0;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } muldiv_state_t;

    // Highest-priority reason for a stall, used by the statistics logic
    typedef enum logic [2:0] {
        HZ_NONE    = 3'd0,
        HZ_LOADUSE = 3'd1,
        HZ_RAW     = 3'd2,
        HZ_WAW     = 3'd3,
        HZ_STRUCT  = 3'd4
    } hazard_cause_t;

endpackage
`default_nettype wire

// File: rtl/hazard_detection_unit_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Per-register pending-write bits for in-flight mul/div results
//               with three pend() lookup ports. A completion in the current
//               cycle is already visible (regfile write-through).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_detection_unit_pkg::*;
#(
    parameter int NREG = 32,
    parameter int RIDW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_set_en,
    input  logic [RIDW-1:0] i_set_idx,
    input  logic            i_clr_en,
    input  logic [RIDW-1:0] i_clr_idx,
    input  logic [RIDW-1:0] i_rs1_idx,
    input  logic [RIDW-1:0] i_rs2_idx,
    input  logic [RIDW-1:0] i_rd_idx,
    output logic            o_rs1_pend,
    output logic            o_rs2_pend,
    output logic            o_rd_pend
);

    logic [NREG-1:0] w_sb;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_bits
            if (gi == REG_ZERO) begin : g_zero
                assign w_sb[gi] = 1'b0;
            end else begin : g_flop
                logic r_bit;
                // Set has priority over a same-cycle clear of the same bit
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_bit <= 1'b0;
                    end else if (i_set_en && (i_set_idx == RIDW'(gi))) begin
                        r_bit <= 1'b1;
                    end else if (i_clr_en && (i_clr_idx == RIDW'(gi))) begin
                        r_bit <= 1'b0;
                    end
                end
                assign w_sb[gi] = r_bit;
            end
        end
    endgenerate

    // pend(r): pending and not being written back this very cycle
    always_comb begin
        o_rs1_pend = w_sb[i_rs1_idx] && !(i_clr_en && (i_clr_idx == i_rs1_idx));
        o_rs2_pend = w_sb[i_rs2_idx] && !(i_clr_en && (i_clr_idx == i_rs2_idx));
        o_rd_pend  = w_sb[i_rd_idx]  && !(i_clr_en && (i_clr_idx == i_rd_idx));
    end

endmodule
`default_nettype wire

// File: rtl/hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detection_unit
// Description : ID-stage detection of hazards bypassing cannot resolve
//               (load-use, pending mul/div RAW/WAW, mul/div structural) and
//               branch redirect flush. Optional macro HAZARD_STATS_EN adds
//               saturating stall/flush/load-use event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int NREG = 32,
    parameter int RIDW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RIDW-1:0] id_rs1_id,
    input  logic [RIDW-1:0] id_rs2_id,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [RIDW-1:0] id_rdst_id,
    input  logic            id_we_regfile,
    input  logic            id_is_muldiv,
    input  logic            ex_is_load,
    input  logic [RIDW-1:0] ex_rdst_id,
    input  logic            ex_branch_taken,
    input  logic            muldiv_done,
    input  logic [RIDW-1:0] muldiv_rdst_id,
    output logic            stall_if,
    output logic            stall_id,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            muldiv_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count,
    output logic [31:0]     loaduse_count
`endif
);

    localparam logic [RIDW-1:0] C_X0 = RIDW'(REG_ZERO);

    muldiv_state_t r_state;
    muldiv_state_t w_state_nxt;

    logic w_rs1_pend, w_rs2_pend, w_rd_pend;
    logic w_loaduse, w_raw, w_waw, w_struct, w_hz;
    logic w_stall, w_issue, w_md_issue, w_sb_set;

    hazard_scoreboard #(
        .NREG (NREG),
        .RIDW (RIDW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (w_sb_set),
        .i_set_idx  (id_rdst_id),
        .i_clr_en   (muldiv_done),
        .i_clr_idx  (muldiv_rdst_id),
        .i_rs1_idx  (id_rs1_id),
        .i_rs2_idx  (id_rs2_id),
        .i_rd_idx   (id_rdst_id),
        .o_rs1_pend (w_rs1_pend),
        .o_rs2_pend (w_rs2_pend),
        .o_rd_pend  (w_rd_pend)
    );

    // Hazard classification, stall/flush generation and issue qualification
    always_comb begin
        w_loaduse  = ex_is_load && (ex_rdst_id != C_X0) &&
                     ((id_rs1_used && (id_rs1_id == ex_rdst_id)) ||
                      (id_rs2_used && (id_rs2_id == ex_rdst_id)));
        w_raw      = (id_rs1_used && w_rs1_pend) || (id_rs2_used && w_rs2_pend);
        w_waw      = id_we_regfile && w_rd_pend;
        w_struct   = id_is_muldiv && muldiv_busy && !muldiv_done;
        w_hz       = id_valid && (w_loaduse || w_raw || w_waw || w_struct);
        // A redirect kills the ID instruction, so stalling it is pointless
        w_stall    = w_hz && !ex_branch_taken;
        w_issue    = id_valid && !w_stall && !ex_branch_taken;
        w_md_issue = w_issue && id_is_muldiv;
        w_sb_set   = w_md_issue && id_we_regfile && (id_rdst_id != C_X0);
    end

    assign stall_if    = w_stall;
    assign stall_id    = w_stall;
    assign flush_if_id = ex_branch_taken;
    assign flush_id_ex = ex_branch_taken;
    assign muldiv_busy = (r_state == MD_BUSY);

    // Mul/div occupancy state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Mul/div next state: a completion with a back-to-back issue stays busy
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: if (w_md_issue) w_state_nxt = MD_BUSY;
            MD_BUSY: if (muldiv_done && !w_md_issue) w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    a_done_while_idle: assert property (@(posedge clk) disable iff (rst)
        !(muldiv_done && (r_state == MD_IDLE)));

`ifdef HAZARD_STATS_EN
    hazard_cause_t w_cause;

    // Highest-priority cause of the current stall
    always_comb begin
        w_cause = HZ_NONE;
        if (w_stall) begin
            if (w_loaduse)      w_cause = HZ_LOADUSE;
            else if (w_raw)     w_cause = HZ_RAW;
            else if (w_waw)     w_cause = HZ_WAW;
            else if (w_struct)  w_cause = HZ_STRUCT;
        end
    end

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles  <= '0;
            flush_count   <= '0;
            loaduse_count <= '0;
        end else begin
            if (w_stall && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (ex_branch_taken && (flush_count != 32'hFFFF_FFFF))
                flush_count <= flush_count + 32'd1;
            if ((w_cause == HZ_LOADUSE) && (loaduse_count != 32'hFFFF_FFFF))
                loaduse_count <= loaduse_count + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_detection_unit
// Description : Directed self-checking bench for hazard_detection_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_detection_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs1_used, id_rs2_used, id_we_regfile, id_is_muldiv;
    logic [4:0] id_rs1_id, id_rs2_id, id_rdst_id, ex_rdst_id, muldiv_rdst_id;
    logic       ex_is_load, ex_branch_taken, muldiv_done;
    logic       stall_if, stall_id, flush_if_id, flush_id_ex, muldiv_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_count, loaduse_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    hazard_detection_unit #(.NREG(32), .RIDW(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1_id       (id_rs1_id),
        .id_rs2_id       (id_rs2_id),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_rdst_id      (id_rdst_id),
        .id_we_regfile   (id_we_regfile),
        .id_is_muldiv    (id_is_muldiv),
        .ex_is_load      (ex_is_load),
        .ex_rdst_id      (ex_rdst_id),
        .ex_branch_taken (ex_branch_taken),
        .muldiv_done     (muldiv_done),
        .muldiv_rdst_id  (muldiv_rdst_id),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .muldiv_busy     (muldiv_busy)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .loaduse_count   (loaduse_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs1_id = 0; id_rs2_id = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rdst_id = 0; id_we_regfile = 0; id_is_muldiv = 0;
        ex_is_load = 0; ex_rdst_id = 0; ex_branch_taken = 0;
        muldiv_done = 0; muldiv_rdst_id = 0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic we, input logic md);
        id_valid = 1; id_rs1_id = rs1; id_rs1_used = u1; id_rs2_id = rs2; id_rs2_used = u2;
        id_rdst_id = rd; id_we_regfile = we; id_is_muldiv = md;
    endtask

    // Advance one clock; inputs change and outputs are sampled mid-cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_stall(input string tag, input logic exp);
        check({tag, ".stall_if"}, {31'd0, stall_if}, {31'd0, exp});
        check({tag, ".stall_id"}, {31'd0, stall_id}, {31'd0, exp});
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        settle();
        check("rst.busy", {31'd0, muldiv_busy}, 32'd0);
        check_stall("rst", 1'b0);
        check("rst.flush", {30'd0, flush_if_id, flush_id_ex}, 32'd0);
        rst = 0;
        tick();

        // Load-use: load x5 in EX, ID reads x5 -> one-cycle stall
        ex_is_load = 1; ex_rdst_id = 5; set_id(5, 1, 0, 0, 6, 1, 0);
        settle(); check_stall("lu", 1'b1);
        check("lu.flush", {30'd0, flush_if_id, flush_id_ex}, 32'd0);
        tick();
        ex_is_load = 0; ex_rdst_id = 0;
        settle(); check_stall("lu.release", 1'b0);
        // rs1=x0 never matches, unused rs2 never matches
        ex_is_load = 1; ex_rdst_id = 5; set_id(0, 1, 5, 0, 6, 1, 0);
        settle(); check_stall("lu.x0_unused", 1'b0);
        ex_rdst_id = 0;
        settle(); check_stall("lu.load_x0", 1'b0);
        tick(); idle();

        // RAW on pending mul x7
        set_id(1, 1, 2, 1, 7, 1, 1);
        settle(); check_stall("mul7.issue", 1'b0);
        tick();
        set_id(1, 1, 7, 1, 8, 1, 0);
        settle();
        check("mul7.busy", {31'd0, muldiv_busy}, 32'd1);
        check_stall("raw7.c1", 1'b1);
        tick(); settle(); check_stall("raw7.c2", 1'b1);
        tick();
        muldiv_done = 1; muldiv_rdst_id = 7;
        settle(); check_stall("raw7.done", 1'b0);
        tick();
        muldiv_done = 0; muldiv_rdst_id = 0;
        settle();
        check("raw7.busy_after", {31'd0, muldiv_busy}, 32'd0);
        check_stall("raw7.cleared", 1'b0);
        tick(); idle();

        // Structural: mul x9 behind pending mul x7
        set_id(0, 0, 0, 0, 7, 1, 1);
        tick();
        set_id(0, 0, 0, 0, 9, 1, 1);
        settle(); check_stall("struct.c1", 1'b1);
        tick(); settle(); check_stall("struct.c2", 1'b1);
        tick();
        muldiv_done = 1; muldiv_rdst_id = 7;
        settle(); check_stall("struct.done", 1'b0);
        tick();
        muldiv_done = 0; muldiv_rdst_id = 0;
        set_id(7, 1, 0, 0, 10, 1, 0);
        settle();
        check("struct.busy", {31'd0, muldiv_busy}, 32'd1);
        check_stall("struct.x7_clear", 1'b0);
        set_id(0, 0, 9, 1, 10, 1, 0);
        settle(); check_stall("struct.x9_pend", 1'b1);
        tick();
        muldiv_done = 1; muldiv_rdst_id = 9;
        settle(); check_stall("struct.x9_done", 1'b0);
        tick(); idle();
        settle();
        check("struct.idle", {31'd0, muldiv_busy}, 32'd0);

        // Load-use plus redirect: flush wins, mul x4 not issued
        ex_is_load = 1; ex_rdst_id = 5; ex_branch_taken = 1;
        set_id(5, 1, 0, 0, 4, 1, 1);
        settle();
        check("br.flush_if_id", {31'd0, flush_if_id}, 32'd1);
        check("br.flush_id_ex", {31'd0, flush_id_ex}, 32'd1);
        check_stall("br", 1'b0);
        tick(); idle();
        set_id(4, 1, 0, 0, 6, 1, 0);
        settle();
        check("br.no_busy", {31'd0, muldiv_busy}, 32'd0);
        check_stall("br.no_sb", 1'b0);
        tick(); idle();

        // WAW on pending mul x3, then reset mid-busy
        set_id(0, 0, 0, 0, 3, 1, 1);
        tick();
        set_id(1, 1, 2, 1, 3, 1, 0);
        settle(); check_stall("waw.c1", 1'b1);
        tick(); settle(); check_stall("waw.c2", 1'b1);
        idle(); rst = 1;
        settle(); check_stall("rst_mid.during", 1'b0);
        tick();
        settle(); check("rst_mid.busy", {31'd0, muldiv_busy}, 32'd0);
        rst = 0;
        set_id(3, 1, 0, 0, 3, 1, 1);
        settle(); check_stall("rst_mid.sb_clear", 1'b0);
        tick(); idle();
        muldiv_done = 1; muldiv_rdst_id = 3;
        tick(); idle();
        settle(); check("rst_mid.idle", {31'd0, muldiv_busy}, 32'd0);

`ifdef HAZARD_STATS_EN
        rst = 1; tick(); rst = 0;
        for (int k = 0; k < 3; k++) begin
            ex_is_load = 1; ex_rdst_id = 5; set_id(5, 1, 0, 0, 6, 1, 0);
            tick(); idle(); tick();
        end
        for (int k = 0; k < 2; k++) begin
            ex_branch_taken = 1; tick(); idle();
        end
        settle();
        check("stats.stall_cycles", stall_cycles, 32'd3);
        check("stats.loaduse_count", loaduse_count, 32'd3);
        check("stats.flush_count", flush_count, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
